// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Takes the synchronized system reset and releases NUM_RST downstream reset
//   domains one at a time, lowest index first. All domains are held for
//   HOLD_CYC cycles after the reset input drops. Each released domain must
//   return its ack. STEP_CYC cycles after that ack, the next domain is released.
//   A missing ack past ACK_TIMEOUT cycles re-asserts every domain and sets a
//   sticky fault. A software request restarts the whole sequence.
//
// Ports
//   clk            in   system clock, rising edge
//   async_rst_i    in   asynchronous active-high reset (synchronizer output)
//   sw_rst_req_i   in   single-cycle software restart request
//   stage_ack_i    in   [NUM_RST-1:0] per-domain "out of reset" ack (level)
//   rst_o          out  [NUM_RST-1:0] per-domain reset, active-high, registered
//   seq_done_o     out  all domains released and acked
//   seq_fault_o    out  sticky ack-timeout fault
//   fault_stage_o  out  [$clog2(NUM_RST):0] index of the domain that timed out
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_RST     = 4,
    parameter int HOLD_CYC    = 16,
    parameter int STEP_CYC    = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       async_rst_i,
    input  logic                       sw_rst_req_i,
    input  logic [NUM_RST-1:0]         stage_ack_i,
    output logic [NUM_RST-1:0]         rst_o,
    output logic                       seq_done_o,
    output logic                       seq_fault_o,
    output logic [$clog2(NUM_RST):0]   fault_stage_o
);

    localparam int FS_W = $clog2(NUM_RST) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
    localparam logic              TO_EN     = (ACK_TIMEOUT != 0);
    localparam logic [FS_W-1:0]  IDX_ONE   = FS_W'(1);
    localparam logic [FS_W-1:0]  IDX_LAST  = FS_W'(NUM_RST - 1);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_WAIT_ACK = 3'd1,
        S_GAP      = 3'd2,
        S_DONE     = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [FS_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_RST-1:0]   rst_q, rst_d;
    logic                 done_q, done_d;
    logic                 fault_q, fault_d;
    logic [FS_W-1:0]      fstage_q, fstage_d;
    logic                 ack_sel;
    logic [FS_W-1:0]      idx_nxt;

    // State register
    always_ff @(posedge clk or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q  <= S_HOLD;
            idx_q    <= '0;
            cnt_q    <= '0;
            rst_q    <= '1;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            fstage_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rst_q    <= rst_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            fstage_q <= fstage_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rst_d    = rst_q;
        done_d   = done_q;
        fault_d  = fault_q;
        fstage_d = fstage_q;
        idx_nxt  = idx_q + IDX_ONE;

        // Only the ack of the domain currently being waited on matters.
        ack_sel = 1'b0;
        for (int i = 0; i < NUM_RST; i++) begin
            if (idx_q == FS_W'(i)) ack_sel = stage_ack_i[i];
        end

        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    rst_d[0] = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_ACK: begin
                if (ack_sel) begin
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    rst_d    = '1;
                    fault_d  = 1'b1;
                    fstage_d = idx_q;
                    state_d  = S_FAULT;
                end else if (TO_EN) begin
                    // With the timeout disabled the counter simply parks.
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == STEP_LAST) begin
                    idx_d = idx_nxt;
                    for (int i = 0; i < NUM_RST; i++) begin
                        if (idx_nxt == FS_W'(i)) rst_d[i] = 1'b0;
                    end
                    cnt_d   = '0;
                    state_d = S_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_HOLD;
        endcase

        // Software restart wins over any ack or timeout seen on the same edge.
        if (sw_rst_req_i) begin
            state_d  = S_HOLD;
            idx_d    = '0;
            cnt_d    = '0;
            rst_d    = '1;
            done_d   = 1'b0;
            fault_d  = 1'b0;
            fstage_d = '0;
        end
    end

    // Outputs
    always_comb begin
        rst_o         = rst_q;
        seq_done_o    = done_q;
        seq_fault_o   = fault_q;
        fault_stage_o = fstage_q;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       async_rst;
    logic       sw_req;
    logic [2:0] ack;
    logic [2:0] rst_o;
    logic       done_o;
    logic       fault_o;
    logic [2:0] fstage_o;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .NUM_RST     (3),
        .HOLD_CYC    (4),
        .STEP_CYC    (2),
        .ACK_TIMEOUT (10),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .async_rst_i   (async_rst),
        .sw_rst_req_i  (sw_req),
        .stage_ack_i   (ack),
        .rst_o         (rst_o),
        .seq_done_o    (done_o),
        .seq_fault_o   (fault_o),
        .fault_stage_o (fstage_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait n rising edges, then sample 1 time unit later.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sw();
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
    endtask

    // Full sequence with all acks high, starting just after HOLD was entered
    // with cnt=0 (or between edges just after async reset release).
    task automatic run_seq(input string p);
        tick(3);
        chk({p, "_hold_e3"}, 32'(rst_o), 32'h7);
        tick(1);
        chk({p, "_rel0_e4"}, 32'(rst_o), 32'h6);
        tick(2);
        chk({p, "_gap0_e6"}, 32'(rst_o), 32'h6);
        tick(1);
        chk({p, "_rel1_e7"}, 32'(rst_o), 32'h4);
        tick(2);
        chk({p, "_gap1_e9"}, 32'(rst_o), 32'h4);
        tick(1);
        chk({p, "_rel2_e10"}, 32'(rst_o), 32'h0);
        chk({p, "_notdone_e10"}, 32'(done_o), 32'h0);
        tick(1);
        chk({p, "_done_e11"}, 32'(done_o), 32'h1);
        chk({p, "_rst_e11"}, 32'(rst_o), 32'h0);
    endtask

    initial begin
        async_rst = 1'b1;
        sw_req    = 1'b0;
        ack       = 3'b111;

        // Reset values
        #12;
        chk("rst_rst_o", 32'(rst_o), 32'h7);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_fault", 32'(fault_o), 32'h0);
        chk("rst_fstage", 32'(fstage_o), 32'h0);
        #8;
        async_rst = 1'b0;

        // Scenario 1: basic sequence
        run_seq("s1");
        ack = 3'b000;
        tick(5);
        chk("s1_done_hold", 32'(done_o), 32'h1);
        chk("s1_no_reassert", 32'(rst_o), 32'h0);

        // Scenario 3: software restart from GAP after stage 0
        ack = 3'b111;
        pulse_sw();
        chk("s3_restart_rst", 32'(rst_o), 32'h7);
        chk("s3_restart_done", 32'(done_o), 32'h0);
        tick(5);
        chk("s3_in_gap", 32'(rst_o), 32'h6);
        pulse_sw();
        chk("s3_gap_sw_rst", 32'(rst_o), 32'h7);
        chk("s3_gap_sw_done", 32'(done_o), 32'h0);
        run_seq("s3");

        // Scenario 2: stage 1 ack stuck low, stage 2 ack high is ignored
        ack = 3'b101;
        pulse_sw();
        tick(4);
        chk("s2_rel0", 32'(rst_o), 32'h6);
        tick(3);
        chk("s2_rel1", 32'(rst_o), 32'h4);
        tick(9);
        chk("s2_pre_to_rst", 32'(rst_o), 32'h4);
        chk("s2_pre_to_fault", 32'(fault_o), 32'h0);
        tick(1);
        chk("s2_to_rst", 32'(rst_o), 32'h7);
        chk("s2_to_fault", 32'(fault_o), 32'h1);
        chk("s2_to_fstage", 32'(fstage_o), 32'h1);
        tick(50);
        chk("s2_stay_rst", 32'(rst_o), 32'h7);
        chk("s2_stay_fault", 32'(fault_o), 32'h1);
        chk("s2_stay_done", 32'(done_o), 32'h0);

        // Scenario 6: fix acks, fault persists until software restart
        ack = 3'b111;
        tick(3);
        chk("s6_fault_sticky", 32'(fault_o), 32'h1);
        chk("s6_rst_sticky", 32'(rst_o), 32'h7);
        pulse_sw();
        chk("s6_fault_clr", 32'(fault_o), 32'h0);
        chk("s6_fstage_clr", 32'(fstage_o), 32'h0);
        chk("s6_rst", 32'(rst_o), 32'h7);
        run_seq("s6");

        // Scenario 4: async reset pulse while waiting on stage 2
        ack = 3'b011;
        pulse_sw();
        tick(10);
        chk("s4_wait2_rst", 32'(rst_o), 32'h0);
        tick(2);
        chk("s4_wait2_done", 32'(done_o), 32'h0);
        chk("s4_wait2_rst2", 32'(rst_o), 32'h0);
        #3;
        async_rst = 1'b1;
        #1;
        chk("s4_async_rst", 32'(rst_o), 32'h7);
        chk("s4_async_done", 32'(done_o), 32'h0);
        #1;
        async_rst = 1'b0;
        ack = 3'b111;
        run_seq("s4");

        // Scenario 5: software request and final ack on the same edge
        ack = 3'b011;
        pulse_sw();
        tick(10);
        chk("s5_wait2_rst", 32'(rst_o), 32'h0);
        ack    = 3'b111;
        pulse_sw();
        chk("s5_sw_wins_done", 32'(done_o), 32'h0);
        chk("s5_sw_wins_rst", 32'(rst_o), 32'h7);
        run_seq("s5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
